// File: rtl/vend_pkg.sv
// ============================================================================
// Module : vend_pkg
// Desc   : Shared types, key codes, coin values and item pricing for the
//          vending transaction controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SELECT   = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_RETURN   = 2'd3
  } state_t;

  localparam logic [3:0] KEY_COIN5   = 4'hA;
  localparam logic [3:0] KEY_COIN10  = 4'hB;
  localparam logic [3:0] KEY_CANCEL  = 4'hC;
  localparam logic [3:0] KEY_CONFIRM = 4'hD;

  localparam logic [3:0] ITEM_MIN = 4'd1;
  localparam logic [3:0] ITEM_MAX = 4'd8;

  localparam logic [7:0] COIN5_VALUE  = 8'd5;
  localparam logic [7:0] COIN10_VALUE = 8'd10;

  // Item n costs 5*(n+2); anything outside 1..8 has no price.
  function automatic logic [7:0] price_of(input logic [3:0] item);
    if (item >= ITEM_MIN && item <= ITEM_MAX)
      return 8'd5 * ({4'd0, item} + 8'd2);
    else
      return 8'd0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vend_timer.sv
// ============================================================================
// Module : vend_timer
// Desc   : Loadable dwell up-counter; done pulses while count equals len-1.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vend_timer #(
  parameter int N     = 4,
  parameter int WIDTH = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             run,
  input  logic [WIDTH-1:0] len,
  output logic             done
);

  logic [WIDTH-1:0] r_count;

  // start wins over run so back-to-back dwell phases restart from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_count <= '0;
    else if (start)
      r_count <= '0;
    else if (run)
      r_count <= r_count + 1'b1;
  end

  assign done = run && (r_count == (len - 1'b1));

endmodule

`default_nettype wire

// File: rtl/vend_controller.sv
// ============================================================================
// Module : vend_controller
// Desc   : Keypad vending transaction FSM with credit, dispense and change.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vend_controller
  import vend_pkg::*;
#(
  parameter int DISPENSE_CYCLES = 50_000_000,
  parameter int RETURN_CYCLES   = 50_000_000,
  parameter int MAX_CREDIT      = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_code,
  input  logic       key_pressed,
  output logic [1:0] state,
  output logic [3:0] item,
  output logic [7:0] price,
  output logic [7:0] credit,
  output logic [7:0] change,
  output logic       dispense,
  output logic       deny
);

  localparam int c_TIMER_N = (DISPENSE_CYCLES > RETURN_CYCLES) ? DISPENSE_CYCLES : RETURN_CYCLES;
  localparam int c_TW      = $clog2(c_TIMER_N + 1);
  localparam logic [c_TW-1:0] c_DISP_LEN   = c_TW'(DISPENSE_CYCLES);
  localparam logic [c_TW-1:0] c_RET_LEN    = c_TW'(RETURN_CYCLES);
  localparam logic [8:0]      c_MAX_CREDIT = 9'(MAX_CREDIT);

  logic       r_kp;
  logic       r_press;
  logic [3:0] r_code;
  state_t     r_state;
  logic [3:0] r_item;
  logic [7:0] r_price;
  logic [7:0] r_credit;
  logic [7:0] r_change;
  logic       r_deny;

  state_t     w_state;
  logic [3:0] w_item;
  logic [7:0] w_price;
  logic [7:0] w_credit;
  logic [7:0] w_change;
  logic       w_deny;
  logic       w_start;
  logic       w_run;
  logic       w_done;
  logic [7:0] w_coin;
  logic [8:0] w_coin_sum;
  logic [c_TW-1:0] w_len;

  // Press is registered together with its key code, so it acts one edge later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_kp    <= 1'b0;
      r_press <= 1'b0;
      r_code  <= 4'd0;
    end else begin
      r_kp    <= key_pressed;
      r_press <= key_pressed & ~r_kp;
      r_code  <= key_code;
    end
  end

  assign w_coin     = (r_code == KEY_COIN10) ? COIN10_VALUE : COIN5_VALUE;
  assign w_coin_sum = {1'b0, r_credit} + {1'b0, w_coin};
  assign w_run      = (r_state == ST_DISPENSE) || (r_state == ST_RETURN);
  assign w_len      = (r_state == ST_RETURN) ? c_RET_LEN : c_DISP_LEN;

  vend_timer #(
    .N     (c_TIMER_N),
    .WIDTH (c_TW)
  ) u_timer (
    .clk   (clk),
    .rst   (reset),
    .start (w_start),
    .run   (w_run),
    .len   (w_len),
    .done  (w_done)
  );

  always_comb begin
    w_state  = r_state;
    w_item   = r_item;
    w_price  = r_price;
    w_credit = r_credit;
    w_change = r_change;
    w_deny   = 1'b0;
    w_start  = 1'b0;

    case (r_state)
      ST_IDLE, ST_SELECT: begin
        if (r_press) begin
          if (r_code >= ITEM_MIN && r_code <= ITEM_MAX) begin
            w_item  = r_code;
            w_price = price_of(r_code);
            w_state = ST_SELECT;
          end else if (r_code == 4'd0 || r_code == 4'd9) begin
            w_deny = 1'b1;
          end else if (r_code == KEY_COIN5 || r_code == KEY_COIN10) begin
            if (w_coin_sum > c_MAX_CREDIT)
              w_deny = 1'b1;
            else
              w_credit = w_coin_sum[7:0];
          end else if (r_code == KEY_CANCEL) begin
            w_item  = 4'd0;
            w_price = 8'd0;
            if (r_credit != 8'd0) begin
              w_change = r_credit;
              w_credit = 8'd0;
              w_state  = ST_RETURN;
              w_start  = 1'b1;
            end else begin
              w_state  = ST_IDLE;
            end
          end else if (r_code == KEY_CONFIRM) begin
            if (r_state == ST_SELECT && r_credit >= r_price) begin
              w_state = ST_DISPENSE;
              w_start = 1'b1;
            end else begin
              w_deny  = 1'b1;
            end
          end
        end
      end

      ST_DISPENSE: begin
        if (w_done) begin
          w_change = r_credit - r_price;
          w_credit = 8'd0;
          w_item   = 4'd0;
          w_price  = 8'd0;
          if (r_credit != r_price) begin
            w_state = ST_RETURN;
            w_start = 1'b1;
          end else begin
            w_state = ST_IDLE;
          end
        end
      end

      ST_RETURN: begin
        if (w_done) begin
          w_change = 8'd0;
          w_state  = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_item   <= 4'd0;
      r_price  <= 8'd0;
      r_credit <= 8'd0;
      r_change <= 8'd0;
      r_deny   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_item   <= w_item;
      r_price  <= w_price;
      r_credit <= w_credit;
      r_change <= w_change;
      r_deny   <= w_deny;
    end
  end

  assign state    = r_state;
  assign item     = r_item;
  assign price    = r_price;
  assign credit   = r_credit;
  assign change   = r_change;
  assign dispense = (r_state == ST_DISPENSE);
  assign deny     = r_deny;

endmodule

`default_nettype wire
